// File: rtl/aes192_word_stream_io.sv
// Word-serial front/back end for a combinational AES-192 layer: assembles key and
// plaintext from a 32-bit stream, waits a fixed settle window, streams ciphertext out.
//
// state     | meaning
// IDLE      | waiting for the first word of a key or data frame
// KEY_LOAD  | shifting in key words 2..6
// DATA_LOAD | shifting in plaintext words 2..4
// CALC      | layer inputs frozen, waiting CALC_CYCLES for the layer to settle
// SEND      | returning four ciphertext words, most significant first
module aes192_word_stream_io #(
  parameter int unsigned CALC_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  s_data,
  input  logic         s_is_key,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [31:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [191:0] enc_key,
  output logic [127:0] enc_in,
  input  logic [127:0] enc_out,
  output logic         key_valid,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {IDLE, KEY_LOAD, DATA_LOAD, CALC, SEND} state_t;

  localparam logic [3:0] CALC_LAST = 4'(CALC_CYCLES - 1);

  state_t       state, state_next;
  logic [2:0]   word_cnt;
  logic [3:0]   calc_cnt;
  logic [1:0]   idx;
  logic [127:0] out_reg;
  logic         s_fire;
  logic         m_fire;

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_next = s_is_key ? KEY_LOAD : DATA_LOAD;
      end
      KEY_LOAD: begin
        s_ready = 1'b1;
        if (s_valid && word_cnt == 3'd5) state_next = IDLE;
      end
      DATA_LOAD: begin
        s_ready = 1'b1;
        // A block without a loaded key is dropped here; err is raised in the datapath.
        if (s_valid && word_cnt == 3'd3) state_next = key_valid ? CALC : IDLE;
      end
      CALC: begin
        if (calc_cnt == CALC_LAST) state_next = SEND;
      end
      SEND: begin
        m_valid = 1'b1;
        if (m_ready && idx == 2'd3) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_data = 32'h0;
    if (m_valid) begin
      case (idx)
        2'd0:    m_data = out_reg[127:96];
        2'd1:    m_data = out_reg[95:64];
        2'd2:    m_data = out_reg[63:32];
        default: m_data = out_reg[31:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= 3'd0;
      calc_cnt  <= 4'd0;
      idx       <= 2'd0;
      out_reg   <= 128'h0;
      enc_key   <= 192'h0;
      enc_in    <= 128'h0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (s_fire) begin
            word_cnt <= 3'd1;
            if (s_is_key) begin
              key_valid <= 1'b0;
              enc_key   <= {enc_key[159:0], s_data};
            end else begin
              enc_in <= {enc_in[95:0], s_data};
            end
          end
        end
        KEY_LOAD: begin
          if (s_fire) begin
            enc_key  <= {enc_key[159:0], s_data};
            word_cnt <= word_cnt + 3'd1;
            if (word_cnt == 3'd5) begin
              key_valid <= 1'b1;
              word_cnt  <= 3'd0;
            end
          end
        end
        DATA_LOAD: begin
          if (s_fire) begin
            enc_in   <= {enc_in[95:0], s_data};
            word_cnt <= word_cnt + 3'd1;
            if (word_cnt == 3'd3) begin
              word_cnt <= 3'd0;
              calc_cnt <= 4'd0;
              if (!key_valid) err <= 1'b1;
            end
          end
        end
        CALC: begin
          calc_cnt <= calc_cnt + 4'd1;
          if (calc_cnt == CALC_LAST) begin
            out_reg  <= enc_out;
            idx      <= 2'd0;
            calc_cnt <= 4'd0;
          end
        end
        SEND: begin
          if (m_fire) idx <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes192_word_stream_io.sv
// Bench for aes192_word_stream_io: a stub layer plus a frame-level model of key state
// and expected ciphertext blocks, with directed and randomized frames.
module tb_aes192_word_stream_io;

  localparam int CALC = 4;
  localparam logic [191:0] FIPS_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  s_data = 32'h0;
  logic         s_is_key = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [191:0] enc_key;
  logic [127:0] enc_in;
  logic [127:0] enc_out;
  logic         key_valid;
  logic         busy;
  logic         err;

  int vectors = 0;
  int miscompares = 0;

  logic [191:0] mdl_key = '0;
  bit           mdl_kv = 1'b0;

  aes192_word_stream_io #(.CALC_CYCLES(CALC)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_is_key(s_is_key), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .enc_key(enc_key), .enc_in(enc_in), .enc_out(enc_out), .key_valid(key_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Stand-in for the encryption layer: exact for the FIPS-197 vector, a keyed mix otherwise.
  function automatic logic [127:0] layer(input logic [191:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {p[63:0], p[127:64]} ^ k[191:64] ^ {k[63:0], k[191:128]};
  endfunction

  assign enc_out = layer(enc_key, enc_in);

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input bit k);
    int t = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = w; s_is_key = k;
    while (!s_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("push_timeout", 1, 0);
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    s_valid = 1'b0; s_data = $urandom; s_is_key = 1'($urandom);
  endtask

  task automatic send_key(input logic [191:0] k, input int gap_at);
    logic [191:0] kk;
    kk = k;
    for (int i = 0; i < 6; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          idle_in();
          chk("gap_kv_low", key_valid, 0);
          chk("gap_busy", busy, 1);
        end
      end
      push(kk[191-32*i -: 32], (i == 0) ? 1'b1 : 1'($urandom));
      #1;
      if (i == 0) begin
        mdl_kv = 1'b0;
        chk("key_valid_drop", key_valid, 0);
      end
    end
    mdl_key = k;
    mdl_kv  = 1'b1;
    chk("key_valid_rise", key_valid, 1);
    chk("enc_key_loaded", enc_key, mdl_key);
    idle_in();
  endtask

  task automatic send_data(input logic [127:0] d);
    logic [127:0] dd;
    dd = d;
    for (int i = 0; i < 4; i++) push(dd[127-32*i -: 32], (i == 0) ? 1'b0 : 1'($urandom));
  endtask

  // Latency, hold, and output checks for one block; stall_mode 0 = ready high,
  // 1 = random ready, 2 = ready low 5 cycles at word 1. Stops before word stop_at.
  task automatic check_block(input logic [127:0] d, input int stall_mode, input int stop_at);
    logic [127:0] exp;
    int cnt = 0, got = 0, cyc = 0, stall = 0;
    exp = layer(mdl_key, d);
    @(negedge clk);
    s_valid = 1'b0;
    chk("enc_in_loaded", enc_in, d);
    chk("calc_s_ready", s_ready, 0);
    while (!m_valid && cnt < 40) begin
      chk("calc_enc_key_hold", enc_key, mdl_key);
      @(posedge clk); cnt++; @(negedge clk);
    end
    chk("latency", cnt, CALC);
    while (got < 4 && cyc < 100) begin
      if (got == stop_at) return;
      if (stall_mode == 0) m_ready = 1'b1;
      else if (stall_mode == 1) m_ready = 1'($urandom);
      else if (got == 1 && stall < 5) begin m_ready = 1'b0; stall++; end
      else m_ready = 1'b1;
      chk("m_valid", m_valid, 1);
      chk("m_data", m_data, exp[127-32*got -: 32]);
      chk("send_s_ready", s_ready, 0);
      if (m_ready) got++;
      @(posedge clk); @(negedge clk); cyc++;
    end
    if (stall_mode == 0) chk("burst_len", cyc, 4);
    if (stall_mode == 2) chk("stall_len", stall, 5);
    chk("words_out", got, 4);
    m_ready = 1'b0;
    chk("end_m_valid", m_valid, 0);
    chk("end_s_ready", s_ready, 1);
    chk("end_busy", busy, 0);
    chk("key_kept", key_valid, 1);
  endtask

  task automatic err_frame();
    send_data({$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    s_valid = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_idle_s_ready", s_ready, 1);
    chk("err_busy", busy, 0);
    for (int i = 0; i < CALC + 3; i++) begin
      @(negedge clk);
      chk("err_once", err, 0);
      chk("err_no_output", m_valid, 0);
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [191:0] k;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_enc_key", enc_key, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_enc_in", enc_in, 0);

    err_frame();

    send_key(FIPS_KEY, -1);
    send_data(FIPS_PT);
    check_block(FIPS_PT, 0, 4);

    send_data(FIPS_PT);
    check_block(FIPS_PT, 2, 4);

    d = {$urandom, $urandom, $urandom, $urandom};
    send_data(d);
    check_block(d, 0, 4);
    send_data(d);
    check_block(d, 0, 4);

    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_key(k, 3);
    for (int f = 0; f < 4; f++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send_data(d);
      check_block(d, (f == 0) ? 0 : 1, 4);
    end

    d = {$urandom, $urandom, $urandom, $urandom};
    send_data(d);
    check_block(d, 0, 2);
    rst_n = 1'b0;
    mdl_kv = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_key_valid", key_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_enc_key", enc_key, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    err_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
